gb_oam_dma_gen: RTL and testbench

Parametrised OAM DMA engine with integrated object attribute memory. It copies a configurable-length block from the external bus into OAM, arbitrates CPU access during transfers, and serves whole 4-byte objects to the PPU sprite fetcher. It adds configurable object count, startup delay, source read latency, restart-on-retrigger and deterministic reset clearing.

---
 rtl/gb_oam_dma_gen.sv | 191 +++++++++++++++++++
 tb/tb_gb_oam_dma_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gb_oam_dma_gen.sv
// gb_oam_dma_gen
// OAM DMA engine with integrated object attribute memory (4*NUM_OBJS bytes).
// A one-cycle trigger copies a block from the external bus into OAM. The block
// starts at {dma_start_addr[15:8], 8'h00}. The CPU is locked out while a
// transfer runs, and the PPU fetches whole 4-byte objects combinationally.
//
// Ports:
//   clk             system clock, all state on the rising edge
//   reset           synchronous active-low reset (clears OAM, aborts DMA)
//   dma_start       one-cycle trigger (also retriggers a running transfer)
//   dma_start_addr  source page in bits [15:8]
//   data_dma_i      source read data (SRC_LATENCY cycles after addr_dma_o)
//   addr_cpu_i      CPU address
//   data_cpu_i      CPU write data
//   wren_cpu        CPU write strobe
//   index_ppu_i     PPU object index
//   dma_active      transfer in progress (delay, read or drain stage)
//   addr_dma_o      source read address, holds its last value outside XFER
//   data_o          CPU read data (8'hFF when out of range or locked out)
//   obj_o           {Y, X, tile, flags} of object index_ppu_i
module gb_oam_dma_gen #(
    parameter int unsigned NUM_OBJS      = 40,
    parameter logic [15:0] OAM_BASE      = 16'hFE00,
    parameter int unsigned STARTUP_DELAY = 1,
    parameter int unsigned SRC_LATENCY   = 0,
    localparam int unsigned IW           = (NUM_OBJS > 1) ? $clog2(NUM_OBJS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dma_start,
    input  logic [15:0]   dma_start_addr,
    input  logic [7:0]    data_dma_i,
    input  logic [15:0]   addr_cpu_i,
    input  logic [7:0]    data_cpu_i,
    input  logic          wren_cpu,
    input  logic [IW-1:0] index_ppu_i,
    output logic          dma_active,
    output logic [15:0]   addr_dma_o,
    output logic [7:0]    data_o,
    output logic [31:0]   obj_o
);

    localparam int unsigned LEN = 4 * NUM_OBJS;
    localparam int unsigned AW  = $clog2(LEN);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_XFER, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [2:0]      dly_q, dly_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      base_q, base_d;
    logic [15:0]     addr_q, addr_d;
    logic            pend_q, pend_d;
    logic [AW-1:0]   pidx_q, pidx_d;

    logic            dma_wr_en;
    logic [AW-1:0]   dma_wr_idx;

    logic [7:0]      mem_q [LEN];

    logic [15:0]     cpu_off;
    logic            cpu_in_range;
    logic            cpu_wr;
    logic [AW-1:0]   obj_idx;
    logic            unused_addr_lo;

    assign unused_addr_lo = ^dma_start_addr[7:0];

    assign dma_active = (state_q != S_IDLE);
    assign addr_dma_o = addr_q;

    // ------------------------------------------------------------------
    // FSM state and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            dly_q   <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            pend_q  <= 1'b0;
            pidx_q  <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            pidx_q  <= pidx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        addr_d     = addr_q;
        pend_d     = 1'b0;
        pidx_d     = pidx_q;
        dma_wr_en  = 1'b0;
        dma_wr_idx = cnt_q[AW-1:0];

        // With one cycle of source latency the write trails the address by
        // one edge, so it is driven from the pending-write stage.
        if (SRC_LATENCY != 0) begin
            dma_wr_en  = pend_q;
            dma_wr_idx = pidx_q;
        end

        case (state_q)
            S_IDLE: ;
            S_DELAY: begin
                if (dly_q == '0) begin
                    state_d = S_XFER;
                    addr_d  = {base_q, 8'h00};
                end else begin
                    dly_d = dly_q - 3'd1;
                end
            end
            S_XFER: begin
                if (SRC_LATENCY == 0) begin
                    dma_wr_en = 1'b1;
                end else begin
                    pend_d = 1'b1;
                    pidx_d = cnt_q[AW-1:0];
                end
                if (cnt_q == 8'(LEN - 1)) begin
                    state_d = (SRC_LATENCY != 0) ? S_DRAIN : S_IDLE;
                end else begin
                    cnt_d  = cnt_q + 8'd1;
                    addr_d = {base_q, cnt_q + 8'd1};
                end
            end
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A trigger in any state restarts the transfer; a pending delayed
        // write from the old transfer is discarded.
        if (dma_start) begin
            base_d = dma_start_addr[15:8];
            cnt_d  = '0;
            pend_d = 1'b0;
            if (SRC_LATENCY != 0) begin
                dma_wr_en = 1'b0;
            end
            if (STARTUP_DELAY == 0) begin
                state_d = S_XFER;
                addr_d  = {dma_start_addr[15:8], 8'h00};
            end else begin
                state_d = S_DELAY;
                dly_d   = 3'(STARTUP_DELAY - 1);
                addr_d  = addr_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // CPU decode and OAM storage
    // ------------------------------------------------------------------
    assign cpu_off      = addr_cpu_i - OAM_BASE;
    assign cpu_in_range = (addr_cpu_i >= OAM_BASE) && (32'(cpu_off) < LEN);
    assign cpu_wr       = wren_cpu && cpu_in_range && !dma_active;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q <= '{default: '0};
        end else begin
            if (dma_wr_en) begin
                mem_q[dma_wr_idx] <= data_dma_i;
            end
            if (cpu_wr) begin
                mem_q[cpu_off[AW-1:0]] <= data_cpu_i;
            end
        end
    end

    assign data_o = (cpu_in_range && !dma_active) ? mem_q[cpu_off[AW-1:0]] : 8'hFF;

    assign obj_idx = AW'({index_ppu_i, 2'b00});
    assign obj_o   = (32'(index_ppu_i) < NUM_OBJS)
                   ? {mem_q[obj_idx],
                      mem_q[{obj_idx[AW-1:2], 2'b01}],
                      mem_q[{obj_idx[AW-1:2], 2'b10}],
                      mem_q[{obj_idx[AW-1:2], 2'b11}]}
                   : '1;

endmodule

// File: tb/tb_gb_oam_dma_gen.sv
// Testbench for gb_oam_dma_gen: a default instance (40 objects, delay 1,
// latency 0) and a small variant (10 objects, delay 0, latency 1).
module tb_gb_oam_dma_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;

    // default instance
    logic        start1 = 1'b0;
    logic [15:0] saddr1 = '0;
    logic [7:0]  ddma1;
    logic [15:0] acpu1 = 16'hFE00;
    logic [7:0]  dcpu1 = '0;
    logic        wr1 = 1'b0;
    logic [5:0]  idx1 = '0;
    logic        act1;
    logic [15:0] adma1;
    logic [7:0]  dout1;
    logic [31:0] obj1;

    // variant instance
    logic        start2 = 1'b0;
    logic [15:0] saddr2 = '0;
    logic [7:0]  ddma2 = '0;
    logic [15:0] acpu2 = 16'hFE00;
    logic [7:0]  dcpu2 = '0;
    logic        wr2 = 1'b0;
    logic [3:0]  idx2 = '0;
    logic        act2;
    logic [15:0] adma2;
    logic [7:0]  dout2;
    logic [31:0] obj2;

    assign ddma1 = adma1[7:0] ^ 8'h5A;
    always @(posedge clk) ddma2 <= adma2[7:0] ^ 8'h3C;

    gb_oam_dma_gen dut1 (
        .clk(clk), .reset(rst), .dma_start(start1), .dma_start_addr(saddr1),
        .data_dma_i(ddma1), .addr_cpu_i(acpu1), .data_cpu_i(dcpu1),
        .wren_cpu(wr1), .index_ppu_i(idx1), .dma_active(act1),
        .addr_dma_o(adma1), .data_o(dout1), .obj_o(obj1)
    );

    gb_oam_dma_gen #(.NUM_OBJS(10), .STARTUP_DELAY(0), .SRC_LATENCY(1)) dut2 (
        .clk(clk), .reset(rst), .dma_start(start2), .dma_start_addr(saddr2),
        .data_dma_i(ddma2), .addr_cpu_i(acpu2), .data_cpu_i(dcpu2),
        .wren_cpu(wr2), .index_ppu_i(idx2), .dma_active(act2),
        .addr_dma_o(adma2), .data_o(dout2), .obj_o(obj2)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Follows one transfer on dut1, checking the address of every active
    // cycle against a small model. n counts negedges after the trigger edge.
    // Optional hooks: CPU lockout probe, retrigger, reset, obj probe at n=1.
    task automatic watch1(input logic [15:0] held0, input logic [15:0] base,
                          input int lock_n, input int rt_n, input logic [15:0] rt_addr,
                          input int rs_n, input logic [31:0] obj_n1, input bit obj_en,
                          output int hi);
        logic [15:0] held, cur, exp;
        int t0;
        bit done;
        held = held0;
        cur  = base;
        t0   = 0;
        hi   = 0;
        done = 1'b0;
        for (int n = 1; n <= 400 && !done; n++) begin
            @(negedge clk);
            start1 = 1'b0;
            wr1    = 1'b0;
            if (n == lock_n) begin
                acpu1 = 16'hFE04;
                dcpu1 = 8'h33;
                wr1   = 1'b1;
            end
            if (n == rt_n) begin
                start1 = 1'b1;
                saddr1 = rt_addr;
            end
            if (n == rs_n) rst = 1'b0;
            #1;
            if (!act1) begin
                done = 1'b1;
            end else begin
                hi++;
                exp = (n - t0 == 1) ? held : cur + 16'(n - t0 - 2);
                chk($sformatf("addr n=%0d", n), adma1, exp);
                if (n == lock_n) chk("cpu_read_locked", dout1, 8'hFF);
                if (n == 1 && obj_en) chk("obj_mid_dma", obj1, obj_n1);
                if (n == rt_n) begin
                    held = exp;
                    cur  = {rt_addr[15:8], 8'h00};
                    t0   = n;
                end
            end
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [5:0]  idx;
        logic [7:0]  exp_d;
        logic [31:0] exp_o;
    } vec_t;

    vec_t vecs [6];
    int   hi;

    initial begin
        // expected OAM after a transfer from page C0: byte i = i ^ 8'h5A
        vecs[0] = '{16'hFE00, 6'd0,  8'h5A, 32'h5A5B5859};
        vecs[1] = '{16'hFE9F, 6'd39, 8'hC5, 32'hC6C7C4C5};
        vecs[2] = '{16'hFEA0, 6'd1,  8'hFF, 32'h5E5F5C5D};
        vecs[3] = '{16'hFDFF, 6'd20, 8'hFF, 32'h0A0B0809};
        vecs[4] = '{16'hFE50, 6'd63, 8'h0A, 32'hFFFFFFFF};
        vecs[5] = '{16'hFE04, 6'd40, 8'h5E, 32'hFFFFFFFF};

        // reset for two edges, with a trigger that must be ignored
        @(negedge clk); rst = 1'b0; start1 = 1'b1; saddr1 = 16'hC012;
        @(negedge clk); start1 = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); acpu1 = 16'hFE00; idx1 = 6'd5;
        #1;
        chk("rst_active", act1, 1'b0);
        chk("rst_addr", adma1, 16'h0000);
        chk("rst_data_in", dout1, 8'h00);
        chk("rst_obj5", obj1, 32'h0);
        chk("rst_active2", act2, 1'b0);
        acpu1 = 16'hFEA0;
        #1 chk("rst_data_out", dout1, 8'hFF);

        // default transfer with lockout probe at n=100 (byte 98)
        @(negedge clk); start1 = 1'b1; saddr1 = 16'hC012;
        watch1(16'h0000, 16'hC000, 100, 0, 16'h0, 0, 32'h0, 1'b0, hi);
        chk("active_len", hi, 161);

        foreach (vecs[i]) begin
            @(negedge clk);
            acpu1 = vecs[i].addr;
            idx1  = vecs[i].idx;
            #1;
            chk($sformatf("vec%0d data", i), dout1, vecs[i].exp_d);
            chk($sformatf("vec%0d obj", i), obj1, vecs[i].exp_o);
        end

        // CPU write accepted once idle
        @(negedge clk); acpu1 = 16'hFE04; dcpu1 = 8'h33; wr1 = 1'b1;
        @(negedge clk); wr1 = 1'b0;
        #1 chk("cpu_write_idle", dout1, 8'h33);

        // trigger together with a CPU write, then retrigger at byte 80
        @(negedge clk);
        start1 = 1'b1; saddr1 = 16'hC1AB;
        acpu1 = 16'hFE08; dcpu1 = 8'h77; wr1 = 1'b1; idx1 = 6'd2;
        watch1(16'hC09F, 16'hC100, 0, 82, 16'hD000, 0, 32'h77535051, 1'b1, hi);
        chk("retrig_len", hi, 243);
        #1 chk("retrig_final_addr", adma1, 16'hD09F);

        // reset during byte 20
        @(negedge clk); start1 = 1'b1; saddr1 = 16'hC000;
        watch1(16'hD09F, 16'hC000, 0, 0, 16'h0, 22, 32'h0, 1'b0, hi);
        chk("rst_mid_len", hi, 22);
        chk("rst_mid_active", act1, 1'b0);
        chk("rst_mid_addr", adma1, 16'h0000);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_idle", act1, 1'b0);
        idx1 = 6'd5;
        #1 chk("rst_mid_obj5", obj1, 32'h0);
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            acpu1 = 16'hFE00 + 16'(i);
            #1 chk($sformatf("cleared[%0d]", i), dout1, 8'h00);
        end

        // variant: 10 objects, no delay, registered source
        @(negedge clk); start2 = 1'b1; saddr2 = 16'h8055;
        hi = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start2 = 1'b0;
            #1;
            if (!act2) break;
            hi++;
            chk($sformatf("v_addr n=%0d", n), adma2,
                (n <= 40) ? 16'h8000 + 16'(n - 1) : 16'h8027);
        end
        chk("v_active_len", hi, 41);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            acpu2 = 16'hFE00 + 16'(i);
            #1 chk($sformatf("v_oam[%0d]", i), dout2, 8'(i) ^ 8'h3C);
        end
        @(negedge clk); acpu2 = 16'hFE28; idx2 = 4'd10;
        #1;
        chk("v_data_oor", dout2, 8'hFF);
        chk("v_obj_oor", obj2, 32'hFFFFFFFF);
        idx2 = 4'd9;
        #1 chk("v_obj9", obj2, 32'h18191A1B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
